sdram_page_writer: RTL and testbench

- DMA write engine: copies one 256-word page from a dual-port line buffer (A or B, ping-pong) into SDRAM as a single write burst through the sdram_controller write port (wr_req/wr_ack/din/mask).
- Runs on the SDRAM controller clock, alongside the page-read DMA path, which moves data in the opposite direction.
- The requester (display/capture logic) uses the same four-phase req/ack scheme and page addressing as the page-read path.

---
 rtl/sdram_page_writer.sv | 144 ++++++++++++++
 tb/tb_sdram_page_writer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_page_writer.sv
// sdram_page_writer: DMA engine that copies one ping-pong line-buffer page
// into SDRAM as a single write burst through the controller write port.
module sdram_page_writer #(
  parameter int unsigned BURST_LEN   = 256,  // power of two, at most 256
  parameter int unsigned PAGE_GAP    = 8,    // at least 1
  parameter int unsigned SYNC_STAGES = 2     // at least 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_req,
  output logic        dma_ack,
  input  logic [15:0] dma_page_addr,
  input  logic        dma_a_b,
  output logic [7:0]  buf_rdaddress,
  input  logic [15:0] bufA_q,
  input  logic [15:0] bufB_q,
  output logic        busy,
  input  logic        sdram_init_done,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_rw_addr,
  output logic [9:0]  sdram_wr_burst,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_mask
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned GAP_W = (PAGE_GAP > 1) ? $clog2(PAGE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_REQ,
    S_BURST,
    S_GAP,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic [15:0]            page_lat;
  logic                   a_b_lat;
  logic [CNT_W-1:0]       word_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [15:0]            src_q;
  logic                   last_word;

  // Bring the requester's handshake into the controller clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], dma_req};
    end
  end

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign src_q     = a_b_lat ? bufA_q : bufB_q;
  assign last_word = (word_cnt == CNT_W'(BURST_LEN - 1));

  // Page-write sequencer: handshake, burst request, ack-paced data, recovery gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      dma_ack        <= 1'b0;
      busy           <= 1'b0;
      sdram_wr_req   <= 1'b0;
      sdram_rw_addr  <= '0;
      sdram_wr_burst <= '0;
      sdram_din      <= '0;
      sdram_mask     <= '0;
      buf_rdaddress  <= '0;
      page_lat       <= '0;
      a_b_lat        <= 1'b0;
      word_cnt       <= '0;
      gap_cnt        <= '0;
    end else begin
      sdram_mask <= 2'b00;
      case (state)
        // Wait for a fresh request; hold it pending until the controller is up.
        S_IDLE: begin
          if (req_s && !dma_ack && sdram_init_done) begin
            page_lat      <= dma_page_addr;
            a_b_lat       <= dma_a_b;
            buf_rdaddress <= '0;
            word_cnt      <= '0;
            busy          <= 1'b1;
            state         <= S_PREFETCH;
          end
        end

        // Word 0 settles on the buffer output while the burst is requested.
        S_PREFETCH: begin
          sdram_rw_addr  <= {page_lat, 8'h00};
          sdram_wr_burst <= 10'(BURST_LEN);
          sdram_wr_req   <= 1'b1;
          state          <= S_REQ;
        end

        // Every ack cycle consumes one word; a missing ack simply stalls.
        S_REQ, S_BURST: begin
          if (sdram_wr_ack) begin
            sdram_din     <= src_q;
            buf_rdaddress <= buf_rdaddress + 8'd1;
            if (last_word) begin
              sdram_wr_req <= 1'b0;
              word_cnt     <= '0;
              gap_cnt      <= '0;
              state        <= S_GAP;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
              state    <= S_BURST;
            end
          end
        end

        // Give the controller time for write recovery and precharge.
        S_GAP: begin
          if (gap_cnt == GAP_W'(PAGE_GAP - 1)) begin
            dma_ack <= 1'b1;
            state   <= S_DONE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        // Four-phase close: ack stays up until the request is withdrawn.
        S_DONE: begin
          if (!req_s) begin
            dma_ack <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_page_writer.sv
// tb_sdram_page_writer: scoreboard bench with a behavioural controller and line buffers.
module tb_sdram_page_writer;

  localparam int unsigned BURST_LEN   = 256;
  localparam int unsigned PAGE_GAP    = 8;
  localparam int unsigned SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_req;
  logic        dma_ack;
  logic [15:0] dma_page_addr;
  logic        dma_a_b;
  logic [7:0]  buf_rdaddress;
  logic [15:0] bufA_q;
  logic [15:0] bufB_q;
  logic        busy;
  logic        sdram_init_done;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic [23:0] sdram_rw_addr;
  logic [9:0]  sdram_wr_burst;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_mask;

  always #5 clk = ~clk;

  sdram_page_writer #(
    .BURST_LEN   (BURST_LEN),
    .PAGE_GAP    (PAGE_GAP),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .dma_req         (dma_req),
    .dma_ack         (dma_ack),
    .dma_page_addr   (dma_page_addr),
    .dma_a_b         (dma_a_b),
    .buf_rdaddress   (buf_rdaddress),
    .bufA_q          (bufA_q),
    .bufB_q          (bufB_q),
    .busy            (busy),
    .sdram_init_done (sdram_init_done),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rw_addr   (sdram_rw_addr),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_din       (sdram_din),
    .sdram_mask      (sdram_mask)
  );

  // Line buffers: read data follows the registered read address.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  assign bufA_q = mem_a[buf_rdaddress];
  assign bufB_q = mem_b[buf_rdaddress];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= reset;

  // Scoreboard queues filled when a page is requested.
  logic [15:0] exp_words [$];
  logic [23:0] exp_addr  [$];
  logic [15:0] exp_last;

  int ctl_lat       = 5;
  bit ctl_holes     = 0;
  int words_seen    = 0;
  int last_ack_edge = 0;
  int ctl_phase     = 0;
  int ctl_wait      = 0;
  int ctl_left      = 0;
  bit ctl_ack       = 0;
  logic [15:0] ctl_w;
  logic ack_prev    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: accepts the write request, acks after a latency, latches data.
  initial begin
    sdram_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        ctl_phase = 0;
        ctl_ack   = 0;
      end else begin
        if (ctl_ack) begin
          if (exp_words.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            ctl_w = exp_words.pop_front();
            chk("burst_word", 32'(sdram_din), 32'(ctl_w));
          end
        end
        ctl_ack = 0;
        case (ctl_phase)
          0: if (sdram_wr_req) begin
            if (exp_addr.size() == 0) chk("unexpected_wr_req", 1, 0);
            else chk("rw_addr", 32'(sdram_rw_addr), 32'(exp_addr.pop_front()));
            chk("wr_burst", 32'(sdram_wr_burst), BURST_LEN);
            chk("mask", 32'(sdram_mask), 0);
            ctl_wait   = ctl_lat;
            words_seen = 0;
            ctl_phase  = 1;
          end
          1: begin
            if (ctl_wait > 1) ctl_wait--;
            else begin
              ctl_left  = BURST_LEN;
              ctl_phase = 2;
            end
          end
          2: begin
            if (!(ctl_holes && ctl_left != BURST_LEN && $urandom_range(0, 7) == 0)) begin
              ctl_ack = 1;
              ctl_left--;
              words_seen++;
              if (ctl_left == 0) begin
                last_ack_edge = cyc + 1;
                ctl_phase     = 3;
              end
            end
          end
          default: begin
            chk("wr_req_drop", 32'(sdram_wr_req), 0);
            ctl_phase = 0;
          end
        endcase
      end
      sdram_wr_ack = ctl_ack;
    end
  end

  // Page-done monitor: gap length, final address wrap and held data.
  initial begin
    forever begin
      @(negedge clk);
      if (dma_ack && !ack_prev && !rst_seen) begin
        chk("ack_gap", 32'(cyc - last_ack_edge), PAGE_GAP);
        chk("rdaddr_wrap", 32'(buf_rdaddress), 32'(8'(BURST_LEN)));
        chk("din_hold_last", 32'(sdram_din), 32'(exp_last));
      end
      ack_prev = dma_ack;
    end
  end

  task automatic issue(input logic [15:0] page, input bit ab);
    exp_addr.push_back(24'(page * 256));
    for (int i = 0; i < BURST_LEN; i++) exp_words.push_back(ab ? mem_a[i] : mem_b[i]);
    exp_last      = ab ? mem_a[BURST_LEN-1] : mem_b[BURST_LEN-1];
    words_seen    = 0;
    dma_page_addr = page;
    dma_a_b       = ab;
    dma_req       = 1'b1;
  endtask

  task automatic wait_ack(input logic val, input int budget, output bit ok);
    int n = 0;
    ok = 1;
    while (dma_ack !== val) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        ok = 0;
        break;
      end
    end
  endtask

  task automatic wait_words(input int target, output bit ok);
    int n = 0;
    while (words_seen < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (words_seen >= target);
  endtask

  task automatic finish_normal(input int hold, input string tag);
    bit ok;
    bit stayed;
    int f;
    wait_ack(1'b1, 3000, ok);
    chk({tag, "_ack_rise"}, 32'(ok), 1);
    stayed = 1;
    repeat (hold) begin
      @(negedge clk);
      if (dma_ack !== 1'b1) stayed = 0;
    end
    if (hold > 0) chk({tag, "_ack_held"}, 32'(stayed), 1);
    dma_req = 1'b0;
    f = cyc;
    wait_ack(1'b0, 50, ok);
    chk({tag, "_ack_fall"}, 32'(ok), 1);
    chk({tag, "_ack_fall_lat"}, 32'(cyc - f), SYNC_STAGES + 1);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
    chk({tag, "_all_words"}, 32'(exp_words.size()), 0);
  endtask

  task automatic finish_drop();
    bit ok;
    wait_words(60, ok);
    chk("drop_reached_burst", 32'(ok), 1);
    dma_req = 1'b0;
    wait_ack(1'b1, 3000, ok);
    chk("drop_ack_rise", 32'(ok), 1);
    @(negedge clk);
    chk("drop_ack_pulse", 32'(dma_ack), 0);
    chk("drop_busy_idle", 32'(busy), 0);
    chk("drop_all_words", 32'(exp_words.size()), 0);
  endtask

  initial begin
    bit ok;
    bit viol;
    reset           = 1'b1;
    dma_req         = 1'b0;
    dma_page_addr   = '0;
    dma_a_b         = 1'b0;
    sdram_init_done = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'hA000 + 16'(i);
      mem_b[i] = 16'hB000 + 16'(i);
    end
    repeat (4) @(negedge clk);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_wr_req", 32'(sdram_wr_req), 0);
    chk("rst_rw_addr", 32'(sdram_rw_addr), 0);
    chk("rst_wr_burst", 32'(sdram_wr_burst), 0);
    chk("rst_din", 32'(sdram_din), 0);
    chk("rst_mask", 32'(sdram_mask), 0);
    chk("rst_rdaddr", 32'(buf_rdaddress), 0);
    chk("rst_busy", 32'(busy), 0);
    reset           = 1'b0;
    sdram_init_done = 1'b1;
    repeat (2) @(negedge clk);

    issue(16'h0012, 1'b1);
    finish_normal(0, "page_a");
    issue(16'h0012, 1'b0);
    finish_normal(0, "page_b");

    // Request raised before the controller finishes initialisation.
    sdram_init_done = 1'b0;
    issue(16'h0040, 1'b1);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (sdram_wr_req || busy) viol = 1;
    end
    chk("init_hold_no_req", 32'(viol), 0);
    sdram_init_done = 1'b1;
    finish_normal(0, "init");

    issue(16'h0012, 1'b1);
    finish_normal(40, "hold");
    issue(16'h0013, 1'b1);
    finish_normal(0, "page13");

    issue(16'h0021, 1'b0);
    finish_drop();

    issue(16'hFFFF, 1'b1);
    finish_normal(0, "top_page");

    // Reset in the middle of a burst.
    issue(16'h0077, 1'b1);
    wait_words(100, ok);
    chk("rstmid_reached", 32'(ok), 1);
    reset   = 1'b1;
    dma_req = 1'b0;
    @(negedge clk);
    chk("rstmid_wr_req", 32'(sdram_wr_req), 0);
    chk("rstmid_dma_ack", 32'(dma_ack), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_rdaddr", 32'(buf_rdaddress), 0);
    reset = 1'b0;
    exp_words.delete();
    exp_addr.delete();
    repeat (5) @(negedge clk);
    issue(16'h0078, 1'b0);
    finish_normal(0, "post_reset");

    // Randomised pages with random data, latency and ack stalls.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = 16'($urandom);
        mem_b[i] = 16'($urandom);
      end
      ctl_lat   = int'($urandom_range(1, 12));
      ctl_holes = 1;
      issue(16'($urandom), 1'($urandom_range(0, 1)));
      finish_normal(int'($urandom_range(0, 5)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
